// File: rtl/fft_mag_sq.sv
// rtl/fft_mag_sq.sv - magnitude-squared stage for FFT output beats with bin tracking and TLAST regeneration
// Define FFT_MAG_SQ_PEAK_EN to add the per-frame peak bin/magnitude outputs.
module fft_mag_sq #(
  parameter int FRAME_LEN     = 1024,
  parameter int BIN_W         = 10,
  parameter int HALF_SPECTRUM = 1
) (
  input  logic             I_CLOCK,
  input  logic             I_RESETN,
  input  logic             S_I_DATA_VALID,
  output logic             S_O_DATA_READY,
  input  logic [31:0]      S_I_DATA,
  input  logic             S_I_DATA_TLAST,
  output logic             M_O_DATA_VALID,
  input  logic             M_I_DATA_READY,
  output logic [31:0]      M_O_DATA,
  output logic             M_O_DATA_TLAST,
  output logic             O_FRAME_ERR
`ifdef FFT_MAG_SQ_PEAK_EN
  ,
  output logic [BIN_W-1:0] O_PEAK_BIN,
  output logic [31:0]      O_PEAK_MAG,
  output logic             O_PEAK_VALID
`endif
);

  localparam logic [BIN_W-1:0] LAST_BIN     = BIN_W'(FRAME_LEN - 1);
  localparam logic [BIN_W-1:0] HALF_LEN     = BIN_W'(FRAME_LEN / 2);
  localparam logic [BIN_W-1:0] OUT_LAST_BIN = (HALF_SPECTRUM != 0) ? BIN_W'(FRAME_LEN / 2 - 1) : LAST_BIN;

  logic             ce;
  logic             accept;
  logic [BIN_W-1:0] bin;
  logic             keep;
  logic signed [15:0] re;
  logic signed [15:0] im;
  logic [30:0]      re_sq;
  logic [30:0]      im_sq;
  logic [31:0]      sum;

  logic             s1_valid;
  logic             s1_keep;
  logic             s1_last;
  logic [30:0]      s1_re_sq;
  logic [30:0]      s1_im_sq;

  assign ce             = !M_O_DATA_VALID || M_I_DATA_READY;
  assign S_O_DATA_READY = ce;
  assign accept         = S_I_DATA_VALID && ce;

  assign re    = S_I_DATA[15:0];
  assign im    = S_I_DATA[31:16];
  // Squares of signed 16-bit values are non-negative and at most 2^30, so 31 bits hold them exactly.
  assign re_sq = re * re;
  assign im_sq = im * im;
  assign keep  = (HALF_SPECTRUM == 0) || (bin < HALF_LEN);
  assign sum   = {1'b0, s1_re_sq} + {1'b0, s1_im_sq};

  // Input TLAST only resyncs the count; output TLAST always comes from the count.
  always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      bin         <= '0;
      O_FRAME_ERR <= 1'b0;
    end else if (accept) begin
      if (S_I_DATA_TLAST || (bin == LAST_BIN)) begin
        bin <= '0;
      end else begin
        bin <= bin + 1'b1;
      end
      if (S_I_DATA_TLAST != (bin == LAST_BIN)) begin
        O_FRAME_ERR <= 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      s1_valid <= 1'b0;
      s1_keep  <= 1'b0;
      s1_last  <= 1'b0;
      s1_re_sq <= '0;
      s1_im_sq <= '0;
    end else if (ce) begin
      s1_valid <= accept;
      if (accept) begin
        s1_keep  <= keep;
        s1_last  <= (bin == OUT_LAST_BIN);
        s1_re_sq <= re_sq;
        s1_im_sq <= im_sq;
      end
    end
  end

  // Dropped bins travel as bubbles and leave the output register untouched.
  always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      M_O_DATA_VALID <= 1'b0;
      M_O_DATA_TLAST <= 1'b0;
      M_O_DATA       <= '0;
    end else if (ce) begin
      M_O_DATA_VALID <= s1_valid && s1_keep;
      M_O_DATA_TLAST <= s1_valid && s1_keep && s1_last;
      if (s1_valid && s1_keep) begin
        M_O_DATA <= sum;
      end
    end
  end

`ifdef FFT_MAG_SQ_PEAK_EN
  logic [BIN_W-1:0] s1_bin;
  logic [BIN_W-1:0] out_bin;
  logic [BIN_W-1:0] run_bin;
  logic [31:0]      run_mag;
  logic             out_fire;
  logic             take;
  logic [BIN_W-1:0] best_bin;
  logic [31:0]      best_mag;

  always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      s1_bin  <= '0;
      out_bin <= '0;
    end else if (ce) begin
      if (accept) begin
        s1_bin <= bin;
      end
      if (s1_valid && s1_keep) begin
        out_bin <= s1_bin;
      end
    end
  end

  assign out_fire = M_O_DATA_VALID && M_I_DATA_READY;
  // Bin 0 opens a new frame; strict compare keeps the lowest bin on ties.
  assign take     = (out_bin == '0) || (M_O_DATA > run_mag);

  always_comb begin
    best_bin = run_bin;
    best_mag = run_mag;
    if (take) begin
      best_bin = out_bin;
      best_mag = M_O_DATA;
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      run_bin      <= '0;
      run_mag      <= '0;
      O_PEAK_BIN   <= '0;
      O_PEAK_MAG   <= '0;
      O_PEAK_VALID <= 1'b0;
    end else begin
      O_PEAK_VALID <= 1'b0;
      if (out_fire) begin
        run_bin <= best_bin;
        run_mag <= best_mag;
        if (M_O_DATA_TLAST) begin
          O_PEAK_BIN   <= best_bin;
          O_PEAK_MAG   <= best_mag;
          O_PEAK_VALID <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_mag_sq.sv
// tb/tb_fft_mag_sq.sv - scoreboard bench for fft_mag_sq with an 8-point half-spectrum frame
module tb_fft_mag_sq;

  localparam int FL = 8;
  localparam int BW = 3;

  logic        I_CLOCK = 1'b0;
  logic        I_RESETN = 1'b0;
  logic        S_I_DATA_VALID = 1'b0;
  logic        S_O_DATA_READY;
  logic [31:0] S_I_DATA = '0;
  logic        S_I_DATA_TLAST = 1'b0;
  logic        M_O_DATA_VALID;
  logic        M_I_DATA_READY = 1'b1;
  logic [31:0] M_O_DATA;
  logic        M_O_DATA_TLAST;
  logic        O_FRAME_ERR;
`ifdef FFT_MAG_SQ_PEAK_EN
  logic [BW-1:0] O_PEAK_BIN;
  logic [31:0]   O_PEAK_MAG;
  logic          O_PEAK_VALID;
`endif

  always #5 I_CLOCK = ~I_CLOCK;

  fft_mag_sq #(.FRAME_LEN(FL), .BIN_W(BW), .HALF_SPECTRUM(1)) dut (
    .I_CLOCK        (I_CLOCK),
    .I_RESETN       (I_RESETN),
    .S_I_DATA_VALID (S_I_DATA_VALID),
    .S_O_DATA_READY (S_O_DATA_READY),
    .S_I_DATA       (S_I_DATA),
    .S_I_DATA_TLAST (S_I_DATA_TLAST),
    .M_O_DATA_VALID (M_O_DATA_VALID),
    .M_I_DATA_READY (M_I_DATA_READY),
    .M_O_DATA       (M_O_DATA),
    .M_O_DATA_TLAST (M_O_DATA_TLAST),
    .O_FRAME_ERR    (O_FRAME_ERR)
`ifdef FFT_MAG_SQ_PEAK_EN
    ,
    .O_PEAK_BIN     (O_PEAK_BIN),
    .O_PEAK_MAG     (O_PEAK_MAG),
    .O_PEAK_VALID   (O_PEAK_VALID)
`endif
  );

  typedef struct {
    logic [31:0] mag;
    logic        last;
    int          bin;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   n_out = 0;
  int   m_bin = 0;
  logic exp_err = 1'b0;
  int   ready_mode = 0;
`ifdef FFT_MAG_SQ_PEAK_EN
  logic [31:0] frame_mags[$];
  logic        peak_pend = 1'b0;
  int          peak_exp_bin = 0;
  logic [31:0] peak_exp_mag = '0;
  int          peak_pulses = 0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: magnitude from plain arithmetic, frame position from the stream of accepted beats.
  function automatic void model_accept(input int re, input int im, input logic last);
    exp_t   e;
    longint m;
    m = longint'(re) * re + longint'(im) * im;
    if (m_bin < FL / 2) begin
      e.mag  = m[31:0];
      e.last = (m_bin == FL / 2 - 1);
      e.bin  = m_bin;
      exp_q.push_back(e);
    end
    if (last != (m_bin == FL - 1)) exp_err = 1'b1;
    m_bin = (last || m_bin == FL - 1) ? 0 : m_bin + 1;
  endfunction

  task automatic send(input int re, input int im, input logic last);
    logic done;
    done = 1'b0;
    S_I_DATA       = {im[15:0], re[15:0]};
    S_I_DATA_TLAST = last;
    S_I_DATA_VALID = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge I_CLOCK);
      if (S_O_DATA_READY) begin
        model_accept(re, im, last);
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: beat not accepted within 1000 cycles");
    end
    @(posedge I_CLOCK);
    #1;
    S_I_DATA_VALID = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 500) begin
      @(negedge I_CLOCK);
      c++;
    end
    check("drain_empty", 64'(exp_q.size()), 0);
    repeat (3) @(posedge I_CLOCK);
    #1;
  endtask

  task automatic do_reset();
    I_RESETN = 1'b0;
    S_I_DATA_VALID = 1'b0;
    #1;
    check("rst_valid", M_O_DATA_VALID, 0);
    check("rst_data", M_O_DATA, 0);
    check("rst_tlast", M_O_DATA_TLAST, 0);
    check("rst_err", O_FRAME_ERR, 0);
`ifdef FFT_MAG_SQ_PEAK_EN
    check("rst_peak_valid", O_PEAK_VALID, 0);
`endif
    exp_q.delete();
    m_bin   = 0;
    exp_err = 1'b0;
    repeat (2) @(posedge I_CLOCK);
    #1;
    I_RESETN = 1'b1;
    @(posedge I_CLOCK);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge I_CLOCK);
      #1;
      case (ready_mode)
        0:       M_I_DATA_READY = 1'b1;
        1:       M_I_DATA_READY = 1'($urandom_range(0, 1));
        default: M_I_DATA_READY = 1'b0;
      endcase
    end
  end

  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    exp_t        e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge I_CLOCK);
      if (!I_RESETN) begin
        prev_stall = 1'b0;
`ifdef FFT_MAG_SQ_PEAK_EN
        peak_pend = 1'b0;
        frame_mags.delete();
`endif
      end else begin
`ifdef FFT_MAG_SQ_PEAK_EN
        check("peak_valid", O_PEAK_VALID, peak_pend);
        if (peak_pend) begin
          check("peak_bin", O_PEAK_BIN, peak_exp_bin);
          check("peak_mag", O_PEAK_MAG, peak_exp_mag);
        end
        if (O_PEAK_VALID) peak_pulses++;
        peak_pend = 1'b0;
`endif
        if (prev_stall) begin
          check("stall_valid", M_O_DATA_VALID, 1);
          check("stall_data", M_O_DATA, prev_data);
          check("stall_tlast", M_O_DATA_TLAST, prev_last);
        end
        if (M_O_DATA_VALID && M_I_DATA_READY) begin
          n_out++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_beat: got data 0x%0h with no expected beat queued", M_O_DATA);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("data_bin%0d", e.bin), M_O_DATA, e.mag);
            check($sformatf("tlast_bin%0d", e.bin), M_O_DATA_TLAST, e.last);
`ifdef FFT_MAG_SQ_PEAK_EN
            if (e.bin == 0) frame_mags.delete();
            frame_mags.push_back(e.mag);
            if (e.last) begin
              peak_exp_bin = 0;
              peak_exp_mag = frame_mags[0];
              foreach (frame_mags[i]) begin
                if (frame_mags[i] > peak_exp_mag) begin
                  peak_exp_mag = frame_mags[i];
                  peak_exp_bin = i;
                end
              end
              peak_pend = 1'b1;
            end
`endif
          end
        end
        prev_stall = M_O_DATA_VALID && !M_I_DATA_READY;
        prev_data  = M_O_DATA;
        prev_last  = M_O_DATA_TLAST;
      end
    end
  end

  initial begin
    int base;
    @(posedge I_CLOCK);
    #1;
    do_reset();

    // single beat latency, then extremes, completing a clean frame
    send(3, -4, 1'b0);
    check("lat_cycle1_valid", M_O_DATA_VALID, 0);
    @(posedge I_CLOCK);
    #1;
    check("lat_cycle2_valid", M_O_DATA_VALID, 1);
    check("lat_cycle2_data", M_O_DATA, 25);
    send(-32768, -32768, 1'b0);
    send(32767, 0, 1'b0);
    for (int k = 3; k < FL; k++) send(k, -k, k == FL - 1);
    drain();
    check("err_clean1", O_FRAME_ERR, 0);

    // continuous ramp frame: 0,1,4,9 with TLAST on 9, upper half dropped
    base = n_out;
    for (int k = 0; k < FL; k++) send(k, 0, k == FL - 1);
    drain();
    check("ramp_out_count", 64'(n_out - base), FL / 2);
    check("err_clean2", O_FRAME_ERR, 0);

    // random data under random backpressure and input gaps
    ready_mode = 1;
    base = n_out;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < FL; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge I_CLOCK);
          #1;
        end
        send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, k == FL - 1);
      end
    end
    drain();
    ready_mode = 0;
    check("rand_out_count", 64'(n_out - base), 3 * FL / 2);
    check("err_rand", O_FRAME_ERR, exp_err);

    // early TLAST on the 5th beat, then a full frame starting at bin 0
    do_reset();
    for (int k = 0; k < 5; k++) send(k + 1, k, k == 4);
    for (int k = 0; k < FL; k++) send(2 * k, 1, k == FL - 1);
    drain();
    check("err_early", O_FRAME_ERR, 1);
    check("err_early_model", O_FRAME_ERR, exp_err);

    // missing TLAST, then a clean frame: flag stays sticky
    do_reset();
    for (int k = 0; k < FL; k++) send(k, k, 1'b0);
    drain();
    check("err_missing", O_FRAME_ERR, 1);
    for (int k = 0; k < FL; k++) send(k, 3, k == FL - 1);
    drain();
    check("err_sticky", O_FRAME_ERR, 1);

    // reset mid-frame while an output beat is stalled
    do_reset();
    ready_mode = 2;
    @(posedge I_CLOCK);
    #1;
    send(7, 1, 1'b0);
    send(2, 2, 1'b0);
    check("stalled_valid_before_rst", M_O_DATA_VALID, 1);
    ready_mode = 0;
    do_reset();
    base = n_out;
    for (int k = 0; k < FL; k++) send(k, k + 1, k == FL - 1);
    drain();
    check("post_rst_out_count", 64'(n_out - base), FL / 2);
    check("post_rst_err", O_FRAME_ERR, 0);

`ifdef FFT_MAG_SQ_PEAK_EN
    // magnitudes 5,9,9,2 in the kept half
    do_reset();
    base = peak_pulses;
    send(1, 2, 1'b0);
    send(3, 0, 1'b0);
    send(0, -3, 1'b0);
    send(1, 1, 1'b0);
    for (int k = 4; k < FL; k++) send(100, 100, k == FL - 1);
    drain();
    check("peak_dir_bin", O_PEAK_BIN, 1);
    check("peak_dir_mag", O_PEAK_MAG, 9);
    check("peak_dir_pulses", 64'(peak_pulses - base), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_mag_sq.md
Name: fft_mag_sq

Overview:
- Downstream stage of the FFT wrapper in the AXI-stream PS-to-PL signal chain.
- Consumes complex FFT output beats and produces one unsigned 32-bit magnitude-squared (re²+im²) per bin.
- Tracks bin index within a frame, optionally drops the redundant upper half spectrum, and regenerates TLAST.
- Flags frames whose input TLAST disagrees with the bin count.

Parameters:
- FRAME_LEN, 1024: FFT points per frame; power of two, 8..65536.
- BIN_W, 10: bin index width; must equal log2(FRAME_LEN).
- HALF_SPECTRUM, 1: 1 = output bins 0..FRAME_LEN/2-1 only; 0 = output all bins.

Ports:
- I_CLOCK  in  1  clock
- I_RESETN  in  1  asynchronous active-low reset
- S_I_DATA_VALID  in  1  input beat valid
- S_O_DATA_READY  out  1  input beat ready
- S_I_DATA  in  32  [15:0] real, [31:16] imag, both signed two's complement
- S_I_DATA_TLAST  in  1  last bin of FFT frame
- M_O_DATA_VALID  out  1  output beat valid
- M_I_DATA_READY  in  1  output beat ready
- M_O_DATA  out  32  unsigned re²+im²
- M_O_DATA_TLAST  out  1  last output bin of frame
- O_FRAME_ERR  out  1  sticky TLAST/count mismatch flag

Behaviour:
- Reset (async assert, sync release): M_O_DATA_VALID=0, M_O_DATA=0, M_O_DATA_TLAST=0, O_FRAME_ERR=0, bin counter=0, all pipeline valids=0. Reset mid-frame discards in-flight beats; the next accepted beat is bin 0.
- Pipeline enable: ce = !M_O_DATA_VALID || M_I_DATA_READY. S_O_DATA_READY = ce (combinational from M_I_DATA_READY). Input accept = S_I_DATA_VALID && ce.
- Stage 1 (on ce): register re*re and im*im as 31-bit unsigned products, plus valid, keep flag, and tlast_out flag.
- Stage 2 (on ce): M_O_DATA = sum, zero-extended to 32 bits. Max is 2×2^30 = 2^31, so no overflow and no saturation. M_O_DATA_VALID = stage-1 valid && keep.
- Latency: 2 cycles from accept to M_O_DATA_VALID with no backpressure. Throughput: 1 beat/cycle.
- While M_O_DATA_VALID=1 and M_I_DATA_READY=0, all stages hold and output data is stable (AXI rule).
- Bin counter (BIN_W bits): increments on each accept; returns to 0 after the beat with bin=FRAME_LEN-1 or after any beat carrying S_I_DATA_TLAST.
- keep = 1 if HALF_SPECTRUM=0, or if bin < FRAME_LEN/2. Dropped beats are still accepted (ready per ce) and flow as bubbles.
- M_O_DATA_TLAST asserts with the bin FRAME_LEN/2-1 output (HALF_SPECTRUM=1) or the bin FRAME_LEN-1 output (HALF_SPECTRUM=0). It is derived from the count, not from input TLAST.
- Error, early case: S_I_DATA_TLAST on bin < FRAME_LEN-1 sets O_FRAME_ERR and resyncs the counter to 0. No TLAST is emitted for that short frame unless its count already reached the output-last bin.
- Error, missing case: bin=FRAME_LEN-1 accepted without TLAST sets O_FRAME_ERR; the counter still wraps to 0.
- O_FRAME_ERR clears only on reset.

Optional Feature:
- Macro: FFT_MAG_SQ_PEAK_EN.
- When defined, adds these outputs:
  - O_PEAK_BIN [BIN_W-1:0]
  - O_PEAK_MAG [31:0]
  - O_PEAK_VALID [1]
- Running max over output bins of the current frame; strictly-greater compare, so the lowest bin wins ties. Bin 0 (DC) is included.
- Running max resets at each frame start.
- On the cycle the TLAST output beat handshakes: registers update and O_PEAK_VALID pulses high for one cycle.
- Reset value of all three outputs: 0.
- When undefined: ports and logic are absent; the module is otherwise identical.

Test Plan:
- Single beat re=3, im=-4, ready=1 held -> M_O_DATA=25 valid exactly 2 cycles after accept.
- Extremes re=-32768, im=-32768 -> M_O_DATA=0x80000000. re=32767, im=0 -> 0x3FFF0001.
- FRAME_LEN=8, HALF_SPECTRUM=1, continuous 8-beat frame (bin k: re=k, im=0), TLAST on 8th beat -> outputs 0,1,4,9 with TLAST on 9; four beats dropped; O_FRAME_ERR=0.
- Random M_I_DATA_READY toggling over 3 frames -> no lost or duplicated beats, output held stable while stalled, output count = 3×FRAME_LEN/2.
- FRAME_LEN=8: TLAST on 5th beat -> O_FRAME_ERR=1, next beat treated as bin 0. Separately, 8 beats without TLAST -> O_FRAME_ERR=1.
- Assert I_RESETN low mid-frame with M_O_DATA_VALID=1 -> valid=0 immediately; after release the next frame is clean. With FFT_MAG_SQ_PEAK_EN, magnitudes 5,9,9,2 -> O_PEAK_BIN=1, O_PEAK_MAG=9, O_PEAK_VALID single pulse.
